// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
// -----------------------------------------------------------------------------
// Shares one bit-serial adder among NREQ requesters. A round-robin arbiter
// picks one active requester in IDLE. The winner gets a one-cycle grant in
// LOAD, and its operands are captured on the edge that ends LOAD. RUN then
// adds them LSB first over WIDTH cycles. DONE publishes the result for one
// cycle. Operation period is WIDTH+3 cycles.
//
// Optional feature (compile-time macro SERIAL_ADD_SUB_EN):
//   adds port sub_bus. If the winner's sub bit is set at capture, the adder
//   computes A-B by inverting B and starting with carry-in 1. In that case
//   cout = 1 means no borrow occurred.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous reset, active low
//   req        - per-requester request (bit i = requester i)
//   a_bus      - packed A operands, slice [i*WIDTH +: WIDTH] for requester i
//   b_bus      - packed B operands, same slicing
//   sub_bus    - (SERIAL_ADD_SUB_EN only) per-requester subtract select
//   gnt        - one-hot grant, high for the single LOAD cycle
//   busy       - high in LOAD, RUN and DONE
//   res        - sum of the last completed operation
//   cout       - final carry of the last completed operation
//   res_id     - requester that owns res
//   res_valid  - one-cycle pulse while in DONE
// -----------------------------------------------------------------------------
module serial_add_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_bus,
    input  logic [NREQ*WIDTH-1:0]   b_bus,
`ifdef SERIAL_ADD_SUB_EN
    input  logic [NREQ-1:0]         sub_bus,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [WIDTH-1:0]        res,
    output logic                    cout,
    output logic [IDW-1:0]          res_id,
    output logic                    res_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDW-1:0]     ptr_reg;      // highest-priority requester
    logic [IDW-1:0]     win_reg;      // requester owning the current operation
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               cout_reg;
    logic [IDW-1:0]     res_id_reg;

    // Unpacked views of the operand buses.
    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Gate the grant bits by state. That keeps gnt at 0 during reset without
    // waiting for a clock edge.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == LOAD) && (win_reg == IDW'(gi));
        end
    endgenerate

    // Subtract select of the winner, sampled at capture only.
    logic sub_sel;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub_bus[win_reg];
`else
    assign sub_sel = 1'b0;
`endif

    // Round-robin pick. Scan from the pointer upward, wrapping at NREQ.
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [IDW-1:0] ptr_next;

    always_comb begin
        logic [IDW-1:0] cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDW'((int'(ptr_reg) + off) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        ptr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    // One full-adder slice on the current LSBs.
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] sum_shift;
    logic             last_bit;

    assign bit_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign bit_carry = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & carry_reg)   |
                       (b_sh_reg[0] & carry_reg);
    // The new bit enters at the MSB. After WIDTH shifts, bit 0 has reached
    // position 0.
    assign sum_cat   = {bit_sum, sum_reg};
    assign sum_shift = sum_cat[WIDTH:1];
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (win_found) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (last_bit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbitration and datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg    <= '0;
            win_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            res_reg    <= '0;
            cout_reg   <= 1'b0;
            res_id_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        win_reg <= win_idx;
                        ptr_reg <= ptr_next;
                    end
                end
                LOAD: begin
                    a_sh_reg  <= a_arr[win_reg];
                    b_sh_reg  <= b_arr[win_reg] ^ {WIDTH{sub_sel}};
                    carry_reg <= sub_sel;
                    cnt_reg   <= '0;
                    sum_reg   <= '0;
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    sum_reg   <= sum_shift;
                    carry_reg <= bit_carry;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Publish on the edge that enters DONE.
                    if (last_bit) begin
                        res_reg    <= sum_shift;
                        cout_reg   <= bit_carry;
                        res_id_reg <= win_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign res_valid = (state_reg == DONE);
    assign res       = res_reg;
    assign cout      = cout_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Testbench for serial_add_scheduler. A reference model is kept here: a
// round-robin pointer plus plain integer addition. Inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_serial_add_scheduler;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_bus;
    logic [N*W-1:0]   b_bus;
    logic [N-1:0]     sub_bus;
    logic [N-1:0]     gnt;
    logic             busy;
    logic [W-1:0]     res;
    logic             cout;
    logic [1:0]       res_id;
    logic             res_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_ptr = 0;
    logic [W-1:0] last_res = '0;
    int gnt_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
`ifdef SERIAL_ADD_SUB_EN
        .sub_bus   (sub_bus),
`endif
        .gnt       (gnt),
        .busy      (busy),
        .res       (res),
        .cout      (cout),
        .res_id    (res_id),
        .res_valid (res_valid)
    );

    function automatic int pick(input logic [N-1:0] r, input int p);
        int i;
        for (int o = 0; o < N; o++) begin
            i = (p + o) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Runs one full operation. The caller is at a falling edge with the DUT
    // able to arbitrate on the next rising edge. The task returns at the
    // falling edge of the DONE cycle.
    task automatic run_op(input logic [N-1:0] r, input logic [N*W-1:0] a,
                          input logic [N*W-1:0] b, input logic [N-1:0] s,
                          input bit hold, input bit scramble);
        int w;
        logic [W-1:0] as, bs;
        logic [W:0]   tot;
        logic [N-1:0] exp_g;
        w = pick(r, exp_ptr);
        if (w < 0) w = 0;
        exp_ptr = (w + 1) % N;
        as = a[w*W +: W];
        bs = b[w*W +: W];
        tot = {1'b0, as} + {1'b0, bs};
`ifdef SERIAL_ADD_SUB_EN
        if (s[w]) tot = {1'b0, as} + {1'b0, ~bs} + 17'd1;
`endif
        exp_g = '0;
        exp_g[w] = 1'b1;
        req = r; a_bus = a; b_bus = b; sub_bus = s;
        @(posedge clk); @(negedge clk);
        gnt_cyc = cyc;
        checks++;
        if (gnt !== exp_g) begin
            errors++;
            $display("FAIL grant: gnt=%b expected=%b (req=%b)", gnt, exp_g, r);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_load: busy=%b expected=1", busy);
        end
        if (!hold) req = '0;
        @(negedge clk);
        if (scramble) begin
            a_bus = {$urandom, $urandom};
            b_bus = {$urandom, $urandom};
            sub_bus = N'($urandom);
        end
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL gnt_pulse: gnt=%b expected=0000 after LOAD", gnt);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res !== last_res) begin
            errors++;
            $display("FAIL mid_run: res_valid=%b res=%h expected 0 and %h", res_valid, res, last_res);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res !== tot[W-1:0] || cout !== tot[W] || res_id !== 2'(w)) begin
            errors++;
            $display("FAIL result: valid=%b res=%h cout=%b id=%0d expected 1 %h %b %0d",
                     res_valid, res, cout, res_id, tot[W-1:0], tot[W], w);
        end
        $display("op req=%b winner=%0d A=%h B=%h res=%h cout=%b id=%0d",
                 r, w, as, bs, res, cout, res_id);
        last_res = tot[W-1:0];
        req = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = '0; a_bus = '0; b_bus = '0; sub_bus = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, busy, res, cout, res_id, res_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b busy=%b res=%h cout=%b id=%0d valid=%b expected all 0",
                     gnt, busy, res, cout, res_id, res_valid);
        end
        exp_ptr = 0;
        last_res = '0;
        reset = 1'b1;
    endtask

    // Only req[0], A0=0x1234 and B0=0x4321; this arbitration is the first edge after reset release.
    task automatic test_basic;
        logic [N*W-1:0] a, b;
        int t0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        a[15:0] = 16'h1234; b[15:0] = 16'h4321;
        t0 = cyc;
        run_op(4'b0001, a, b, '0, 1'b0, 1'b0);
        checks++;
        if (cyc - t0 != 18) begin
            errors++;
            $display("FAIL latency: res_valid at cycle offset %0d expected 18", cyc - t0);
        end
    endtask

    task automatic test_carry;
        logic [N*W-1:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        a[47:32] = 16'hFFFF; b[47:32] = 16'h0001;
        @(negedge clk);
        run_op(4'b0100, a, b, '0, 1'b0, 1'b0);
    endtask

    // req[3] is up only for its arbitration edge; operands change after LOAD.
    task automatic test_withdraw;
        @(negedge clk);
        run_op(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin;
        int prev;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            run_op(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b1, 1'b0);
            if (k > 0) begin
                checks++;
                if (gnt_cyc - prev != 19) begin
                    errors++;
                    $display("FAIL gnt_period: %0d cycles expected 19", gnt_cyc - prev);
                end
            end
            prev = gnt_cyc;
        end
    endtask

    task automatic test_abort;
        @(negedge clk);
        req = 4'b0001; a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        req = '0;
        repeat (9) @(negedge clk);   // RUN cycle 8
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, res, cout, res_id, res_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b busy=%b res=%h cout=%b id=%0d valid=%b expected all 0",
                     gnt, busy, res, cout, res_id, res_valid);
        end
        exp_ptr = 0;
        last_res = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL aborted_op: res_valid=%b busy=%b expected 0", res_valid, busy);
            end
        end
        reset = 1'b1;
        run_op(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b0, 1'b0);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        logic [N*W-1:0] a, b;
        a = '0; b = '0;
        a[15:0] = 16'h0005; b[15:0] = 16'h0007;
        @(negedge clk);
        run_op(4'b0001, a, b, 4'b0001, 1'b0, 1'b0);
        checks++;
        if (res !== 16'hFFFE || cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: res=%h cout=%b expected fffe 0", res, cout);
        end
        a[31:16] = 16'h0007; b[31:16] = 16'h0005;
        @(negedge clk);
        run_op(4'b0010, a, b, 4'b0010, 1'b0, 1'b0);
        checks++;
        if (res !== 16'h0002 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_noborrow: res=%h cout=%b expected 0002 1", res, cout);
        end
    endtask
`endif

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(N'($urandom_range(1, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                   N'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_withdraw;
        test_round_robin;
        test_abort;
`ifdef SERIAL_ADD_SUB_EN
        test_sub;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
